// File: rtl/timer_pkg.sv
// Shared types, limits and BCD helpers for the multi-channel MM:SS countdown timer.
package timer_pkg;

  localparam int unsigned BCD_W = 16;
  localparam int unsigned DIG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } ch_state_e;

  localparam logic [BCD_W-1:0] BCD_ZERO = 16'h0000;
  localparam logic [DIG_W-1:0] DIG_MAX9 = 4'd9;
  localparam logic [DIG_W-1:0] DIG_MAX5 = 4'd5;

  typedef struct packed {
    logic [DIG_W-1:0] tens_min;
    logic [DIG_W-1:0] min;
    logic [DIG_W-1:0] tens_sec;
    logic [DIG_W-1:0] sec;
  } bcd_time_t;

  function automatic logic bcd_valid(input bcd_time_t t);
    return (t.tens_min <= DIG_MAX9) && (t.min <= DIG_MAX9) &&
           (t.tens_sec <= DIG_MAX5) && (t.sec <= DIG_MAX9);
  endfunction

  // One-second BCD decrement with borrow chain; saturates at 00:00.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (BCD_W'(t) != BCD_ZERO) begin
      if (t.sec != '0) begin
        r.sec = t.sec - DIG_W'(1);
      end else begin
        r.sec = DIG_MAX9;
        if (t.tens_sec != '0) begin
          r.tens_sec = t.tens_sec - DIG_W'(1);
        end else begin
          r.tens_sec = DIG_MAX5;
          if (t.min != '0) begin
            r.min = t.min - DIG_W'(1);
          end else begin
            r.min      = DIG_MAX9;
            r.tens_min = t.tens_min - DIG_W'(1);
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: FSM, reload/count registers, BCD decrement and sticky done.
module timer_channel
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_value_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             stop_i,
  input  logic             ack_i,
  input  logic             repeat_i,
  output logic [BCD_W-1:0] count_o,
  output logic             running_o,
  output logic             done_o,
  output logic             done_d_c
);

  ch_state_e        state_q, state_d;
  logic [BCD_W-1:0] count_q, count_d;
  logic [BCD_W-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] dec_val;

  assign dec_val = BCD_W'(bcd_dec(bcd_time_t'(count_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= BCD_ZERO;
      reload_q <= BCD_ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Strobes arrive already priority-resolved, so at most one command is set.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;
    if (ack_i) done_d = 1'b0;
    if (stop_i) begin
      state_d = ST_IDLE;
      count_d = reload_q;
    end else if (state_q == ST_RUN) begin
      if (pause_i) begin
        state_d = ST_PAUSE;
      end else if (tick_i) begin
        if (dec_val == BCD_ZERO) begin
          done_d = 1'b1;
          if (repeat_i && (reload_q != BCD_ZERO)) begin
            count_d = reload_q;
          end else begin
            count_d = BCD_ZERO;
            state_d = ST_EXPIRED;
          end
        end else begin
          count_d = dec_val;
        end
      end
    end else if (load_i) begin
      state_d  = ST_IDLE;
      count_d  = load_value_i;
      reload_d = load_value_i;
    end else if (start_i && (state_q != ST_EXPIRED) && (count_q != BCD_ZERO)) begin
      state_d = ST_RUN;
    end
  end

  assign count_o   = count_q;
  assign running_o = (state_q == ST_RUN);
  assign done_o    = done_q;
  assign done_d_c  = done_d;

endmodule

// File: rtl/multi_channel_timer.sv
// NUM_CH independent MM:SS countdown channels on a shared 1 s tick, with command decode and display mux.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              load,
  input  logic [BCD_W-1:0]  load_value,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              ack,
  input  logic [NUM_CH-1:0] repeat_mode,
  output logic [BCD_W-1:0]  disp_digits,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] done,
  output logic              any_done,
  output logic              load_err
);

  logic [NUM_CH-1:0]            hit;
  logic                         sel_valid;
  logic                         load_ok;
  logic                         stop_w, load_w, pause_w, start_w;
  logic [NUM_CH-1:0][BCD_W-1:0] count_w;
  logic [NUM_CH-1:0]            done_nxt;
  logic [BCD_W-1:0]             disp_q, disp_d;
  logic                         load_err_q, load_err_d;
  logic                         any_done_q;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) hit[i] = (ch_sel == CH_W'(i));
  end

  assign sel_valid = |hit;
  assign load_ok   = bcd_valid(bcd_time_t'(load_value));

  // Only the highest-priority asserted command survives: stop > load > pause > start.
  assign stop_w  = stop;
  assign load_w  = load & ~stop;
  assign pause_w = pause & ~stop & ~load;
  assign start_w = start & ~stop & ~load & ~pause;

  assign load_err_d = sel_valid & load_w & ~load_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel u_ch (
      .clk         (clk),
      .rst_n       (reset),
      .tick_i      (tick),
      .load_i      (load_w & load_ok & hit[g]),
      .load_value_i(load_value),
      .start_i     (start_w & hit[g]),
      .pause_i     (pause_w & hit[g]),
      .stop_i      (stop_w & hit[g]),
      .ack_i       (ack & hit[g]),
      .repeat_i    (repeat_mode[g]),
      .count_o     (count_w[g]),
      .running_o   (running[g]),
      .done_o      (done[g]),
      .done_d_c    (done_nxt[g])
    );
  end

  always_comb begin
    disp_d = BCD_ZERO;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (hit[i]) disp_d = count_w[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q     <= BCD_ZERO;
      load_err_q <= 1'b0;
      any_done_q <= 1'b0;
    end else begin
      disp_q     <= disp_d;
      load_err_q <= load_err_d;
      any_done_q <= |done_nxt;
    end
  end

  assign disp_digits = disp_q;
  assign load_err    = load_err_q;
  assign any_done    = any_done_q;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Bench for multi_channel_timer: seconds-based reference model, per-cycle compare, directed and random stimulus.
module tb_multi_channel_timer;

  localparam int NCH = 4;
  localparam int CW  = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
  localparam logic [4:0] C_NONE = 5'b00000, C_STOP = 5'b10000, C_LOAD = 5'b01000,
                         C_PAUSE = 5'b00100, C_START = 5'b00010, C_ACK = 5'b00001;

  logic           clk = 1'b0;
  logic           reset;
  logic           tick;
  logic [CW-1:0]  ch_sel;
  logic           load, start, pause, stop, ack;
  logic [15:0]    load_value;
  logic [NCH-1:0] repeat_mode;
  logic [15:0]    disp_digits;
  logic [NCH-1:0] running, done;
  logic           any_done, load_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int          m_st [NCH];
  int          m_sec[NCH];
  int          m_rel[NCH];
  bit          m_done[NCH];
  logic [15:0] e_disp;
  bit          e_lerr;

  logic [15:0] seq105 [6] = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100, 16'h0059};

  multi_channel_timer #(.NUM_CH(NCH), .CH_W(CW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .ch_sel(ch_sel), .load(load),
    .load_value(load_value), .start(start), .pause(pause), .stop(stop), .ack(ack),
    .repeat_mode(repeat_mode), .disp_digits(disp_digits), .running(running),
    .done(done), .any_done(any_done), .load_err(load_err)
  );

  always #10 clk = ~clk;

  function automatic int bcd2sec(input logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] sec2bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = S_IDLE; m_sec[i] = 0; m_rel[i] = 0; m_done[i] = 1'b0;
    end
    e_disp = 16'h0;
    e_lerr = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: counts held as plain seconds, one command per channel chosen by priority.
  always @(posedge clk or negedge reset) begin
    int sel, cmd;
    if (!reset) begin
      model_reset();
    end else begin
      sel = int'(ch_sel);
      e_disp = (sel < NCH) ? sec2bcd(m_sec[sel]) : 16'h0;
      e_lerr = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cmd = 0;
        if (sel == i) begin
          if (stop) cmd = 1;
          else if (load) cmd = 2;
          else if (pause) cmd = 3;
          else if (start) cmd = 4;
          if (ack) m_done[i] = 1'b0;
        end
        if (cmd == 2 && !bcd_ok(load_value)) e_lerr = 1'b1;
        if (cmd == 1) begin
          m_st[i] = S_IDLE;
          m_sec[i] = m_rel[i];
        end else if (m_st[i] == S_RUN) begin
          if (cmd == 3) m_st[i] = S_PAUSE;
          else if (tick) begin
            m_sec[i] = (m_sec[i] > 0) ? m_sec[i] - 1 : 0;
            if (m_sec[i] == 0) begin
              m_done[i] = 1'b1;
              if (repeat_mode[i] && m_rel[i] != 0) m_sec[i] = m_rel[i];
              else m_st[i] = S_EXP;
            end
          end
        end else if (cmd == 2 && bcd_ok(load_value)) begin
          m_rel[i] = bcd2sec(load_value);
          m_sec[i] = m_rel[i];
          m_st[i] = S_IDLE;
        end else if (cmd == 4 && m_st[i] != S_EXP && m_sec[i] != 0) begin
          m_st[i] = S_RUN;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0] er, ed;
    if (chk_en) begin
      for (int i = 0; i < NCH; i++) begin
        er[i] = (m_st[i] == S_RUN);
        ed[i] = m_done[i];
      end
      chk("disp_digits", 32'(disp_digits), 32'(e_disp));
      chk("running", 32'(running), 32'(er));
      chk("done", 32'(done), 32'(ed));
      chk("any_done", 32'(any_done), 32'(|ed));
      chk("load_err", 32'(load_err), 32'(e_lerr));
    end
  end

  task automatic cyc(input logic [CW-1:0] sel, input logic [4:0] cmd,
                     input logic [15:0] val, input logic tk);
    ch_sel = sel;
    {stop, load, pause, start, ack} = cmd;
    load_value = val;
    tick = tk;
    @(posedge clk);
    #2;
    {stop, load, pause, start, ack} = C_NONE;
    tick = 1'b0;
  endtask

  initial begin
    logic [4:0]  rc;
    logic [15:0] rv;
    int          r;
    model_reset();
    reset = 1'b0; tick = 1'b0; ch_sel = '0; load_value = '0; repeat_mode = '0;
    {stop, load, pause, start, ack} = C_NONE;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    chk_en = 1'b1;
    chk("rst_disp", 32'(disp_digits), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_any_done", 32'(any_done), 32'h0);

    cyc(1, C_LOAD, 16'h0105, 0);
    cyc(1, C_START, 16'h0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(1, C_NONE, 16'h0, 1);
      cyc(1, C_NONE, 16'h0, 0);
      chk("ch1_borrow_seq", 32'(disp_digits), 32'(seq105[k]));
    end

    cyc(0, C_LOAD, 16'h0002, 0);
    cyc(0, C_START, 16'h0, 0);
    cyc(0, C_NONE, 16'h0, 1);
    cyc(0, C_NONE, 16'h0, 1);
    chk("ch0_done", 32'(done[0]), 32'h1);
    chk("ch0_any_done", 32'(any_done), 32'h1);
    chk("ch0_stopped", 32'(running[0]), 32'h0);
    cyc(0, C_NONE, 16'h0, 0);
    chk("ch0_zero", 32'(disp_digits), 32'h0);
    cyc(0, C_ACK, 16'h0, 0);
    chk("ch0_ack", 32'(done[0]), 32'h0);

    repeat_mode = 4'b0100;
    cyc(2, C_LOAD, 16'h0003, 0);
    cyc(2, C_START, 16'h0, 0);
    repeat (3) cyc(2, C_NONE, 16'h0, 1);
    chk("ch2_rep_done", 32'(done[2]), 32'h1);
    chk("ch2_rep_running", 32'(running[2]), 32'h1);
    cyc(2, C_NONE, 16'h0, 0);
    chk("ch2_rep_reload", 32'(disp_digits), 32'h0003);

    cyc(0, C_LOAD, 16'h0065, 0);
    chk("bad_load_err", 32'(load_err), 32'h1);
    cyc(0, C_NONE, 16'h0, 0);
    chk("bad_load_pulse", 32'(load_err), 32'h0);
    chk("bad_load_keep", 32'(disp_digits), 32'h0);

    cyc(0, C_LOAD, 16'h0000, 0);
    cyc(0, C_START, 16'h0, 0);
    chk("zero_start", 32'(running[0]), 32'h0);

    cyc(3, C_LOAD, 16'h0010, 0);
    cyc(3, C_START, 16'h0, 0);
    chk("ch3_run", 32'(running[3]), 32'h1);
    cyc(3, C_PAUSE, 16'h0, 1);
    chk("ch3_pause", 32'(running[3]), 32'h0);
    cyc(3, C_NONE, 16'h0, 0);
    chk("ch3_pause_hold", 32'(disp_digits), 32'h0010);
    cyc(3, C_START, 16'h0, 0);
    cyc(3, C_NONE, 16'h0, 1);
    cyc(3, C_START | C_STOP, 16'h0, 0);
    chk("ch3_stop_wins", 32'(running[3]), 32'h0);
    cyc(3, C_NONE, 16'h0, 0);
    chk("ch3_stop_restore", 32'(disp_digits), 32'h0010);

    cyc(1, C_STOP, 16'h0, 0);
    cyc(2, C_STOP, 16'h0, 0);
    repeat_mode = '0;
    cyc(2, C_ACK, 16'h0, 0);
    cyc(0, C_LOAD, 16'h0002, 0);
    cyc(1, C_LOAD, 16'h0002, 0);
    cyc(0, C_START, 16'h0, 0);
    cyc(1, C_START, 16'h0, 0);
    cyc(1, C_NONE, 16'h0, 1);
    cyc(1, C_NONE, 16'h0, 1);
    chk("pair_done", 32'(done), 32'h3);
    cyc(0, C_ACK, 16'h0, 0);
    chk("pair_ack_one", 32'(done), 32'h2);
    chk("pair_any_done", 32'(any_done), 32'h1);

    cyc(5, C_LOAD, 16'h0030, 0);
    chk("oob_no_err", 32'(load_err), 32'h0);
    cyc(5, C_NONE, 16'h0, 0);
    chk("oob_disp", 32'(disp_digits), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) repeat_mode = 4'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 6) rc = C_STOP;
      else if (r < 16) rc = C_LOAD;
      else if (r < 22) rc = C_PAUSE;
      else if (r < 40) rc = C_START;
      else rc = C_NONE;
      if ($urandom_range(0, 9) == 0) rc = rc | C_ACK;
      if ($urandom_range(0, 15) == 0) rc = rc | 5'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 7) rv = sec2bcd(int'($urandom_range(0, 20)));
      else if (r < 9) rv = sec2bcd(int'($urandom_range(0, 5999)));
      else rv = 16'($urandom);
      cyc(3'($urandom_range(0, 5)), rc, rv, ($urandom_range(0, 2) == 0));
    end

    cyc(1, C_STOP, 16'h0, 0);
    cyc(1, C_LOAD, 16'h0130, 0);
    cyc(1, C_START, 16'h0, 0);
    cyc(1, C_NONE, 16'h0, 1);
    cyc(1, C_NONE, 16'h0, 0);
    chk("pre_reset_disp", 32'(disp_digits), 32'h0129);
    #5;
    reset = 1'b0;
    #1;
    chk("async_rst_disp", 32'(disp_digits), 32'h0);
    chk("async_rst_running", 32'(running), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    chk("async_rst_any_done", 32'(any_done), 32'h0);
    chk("async_rst_load_err", 32'(load_err), 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    cyc(1, C_START, 16'h0, 0);
    chk("post_rst_idle", 32'(running), 32'h0);
    repeat (3) cyc(1, C_NONE, 16'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
